// File: rtl/cpu_registerfile_sb_pkg.sv
// Shared definitions for the register-file slice: default geometry,
// architectural fp/sp indices and the register index type.
package cpu_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_IDX_WIDTH  = 4;
  localparam int DEFAULT_NUM_REGS   = 16;

  localparam int CPU_FP_INDEX = 0;
  localparam int CPU_SP_INDEX = 1;

  typedef logic [DEFAULT_IDX_WIDTH-1:0] reg_idx_t;

endpackage : cpu_pkg

// File: rtl/cpu_registerfile_sb_if.sv
// Port bundle between decode/writeback logic and the register file.
interface cpu_registerfile_sb_if
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int IDX_WIDTH  = DEFAULT_IDX_WIDTH,
  parameter int NUM_REGS   = DEFAULT_NUM_REGS
);

  logic                  we0_i;
  logic [IDX_WIDTH-1:0]  waddr0_i;
  logic [DATA_WIDTH-1:0] wdata0_i;
  logic                  we1_i;
  logic [IDX_WIDTH-1:0]  waddr1_i;
  logic [DATA_WIDTH-1:0] wdata1_i;
  logic [IDX_WIDTH-1:0]  raddr1_i;
  logic [IDX_WIDTH-1:0]  raddr2_i;
  logic [DATA_WIDTH-1:0] rdata1_o;
  logic [DATA_WIDTH-1:0] rdata2_o;
  logic                  mark_busy_i;
  logic [IDX_WIDTH-1:0]  mark_idx_i;
  logic                  busy1_o;
  logic                  busy2_o;
  logic [NUM_REGS-1:0]   busy_vec_o;
  logic [DATA_WIDTH-1:0] fp_o;
  logic [DATA_WIDTH-1:0] sp_o;
  logic                  wr_conflict_o;

  modport master (
    output we0_i, waddr0_i, wdata0_i,
    output we1_i, waddr1_i, wdata1_i,
    output raddr1_i, raddr2_i,
    output mark_busy_i, mark_idx_i,
    input  rdata1_o, rdata2_o, busy1_o, busy2_o, busy_vec_o,
    input  fp_o, sp_o, wr_conflict_o
  );

  modport slave (
    input  we0_i, waddr0_i, wdata0_i,
    input  we1_i, waddr1_i, wdata1_i,
    input  raddr1_i, raddr2_i,
    input  mark_busy_i, mark_idx_i,
    output rdata1_o, rdata2_o, busy1_o, busy2_o, busy_vec_o,
    output fp_o, sp_o, wr_conflict_o
  );

endinterface : cpu_registerfile_sb_if

// File: rtl/cpu_registerfile_sb_scoreboard.sv
// Per-register busy bits tracking outstanding loads, with lookups for the
// two read ports so decode can stall on a pending load.
module cpu_scoreboard #(
  parameter int NUM_REGS  = 16,
  parameter int IDX_WIDTH = 4,
  parameter bit BYPASS    = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 mark_busy_i,
  input  logic [IDX_WIDTH-1:0] mark_idx_i,
  input  logic                 we1_i,
  input  logic [IDX_WIDTH-1:0] waddr1_i,
  input  logic [IDX_WIDTH-1:0] raddr1_i,
  input  logic [IDX_WIDTH-1:0] raddr2_i,
  output logic                 busy1_o,
  output logic                 busy2_o,
  output logic [NUM_REGS-1:0]  busy_vec_o
);

  typedef logic [IDX_WIDTH-1:0] idx_t;

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] clr_vec;

  // Only indices below NUM_REGS have a bit, so out-of-range marks and
  // completions decode to nothing.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    set_vec = '0;
    clr_vec = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      set_vec[i] = mark_busy_i && (mark_idx_i == idx_t'(i));
      clr_vec[i] = we1_i && (waddr1_i == idx_t'(i));
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
      busy_q <= '0;
    end else begin
      // A new load issued as the old one completes keeps the bit set.
      busy_q <= set_vec | (busy_q & ~clr_vec);
    end
  end

  function automatic logic lookup(idx_t raddr);
    logic raw;
    raw = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (raddr == idx_t'(i)) raw = busy_q[i];
    end
    if (BYPASS && we1_i && (raddr == waddr1_i) &&
        !(mark_busy_i && (mark_idx_i == raddr))) begin
      raw = 1'b0;
    end
    return raw;
  endfunction

  always_comb begin
    busy1_o = lookup(raddr1_i);
    busy2_o = lookup(raddr2_i);
  end

  assign busy_vec_o = busy_q;

endmodule : cpu_scoreboard

// File: rtl/cpu_registerfile_sb.sv
// Dual-write, dual-read register file with optional write-to-read bypass,
// load scoreboard and dedicated frame/stack pointer taps.
module cpu_registerfile_sb
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_REGS   = DEFAULT_NUM_REGS,
  parameter int IDX_WIDTH  = DEFAULT_IDX_WIDTH,
  parameter bit BYPASS     = 1'b1,
  parameter int FP_INDEX   = CPU_FP_INDEX,
  parameter int SP_INDEX   = CPU_SP_INDEX
) (
  input logic                  clk_i,
  input logic                  rst_n_i,
  cpu_registerfile_sb_if.slave rf
);

  typedef logic [IDX_WIDTH-1:0]  idx_t;
  typedef logic [DATA_WIDTH-1:0] word_t;

  word_t regs [NUM_REGS];
  logic  wr0_hit;
  logic  wr1_hit;
  logic  same_idx;
  logic  wr_conflict_q;

  function automatic logic in_range(idx_t idx);
    return int'(idx) < NUM_REGS;
  endfunction

  // Out-of-range write indices are dropped here, before they reach the array.
  always_comb begin
    wr0_hit  = rf.we0_i && in_range(rf.waddr0_i);
    wr1_hit  = rf.we1_i && in_range(rf.waddr1_i);
    same_idx = (rf.waddr0_i == rf.waddr1_i);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      // NOTE: the array must clear on reset, so it is built from resettable flops rather than a RAM macro.
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      wr_conflict_q <= wr0_hit && wr1_hit && same_idx;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr1_hit && (rf.waddr1_i == idx_t'(i))) begin
          regs[i] <= rf.wdata1_i;
        end else if (wr0_hit && (rf.waddr0_i == idx_t'(i))) begin
          regs[i] <= rf.wdata0_i;
        end
      end
    end
  end

  // Load writeback (port 1) wins over the ALU both in storage and in bypass.
  function automatic word_t read_port(idx_t raddr);
    word_t value;
    value = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (raddr == idx_t'(i)) value = regs[i];
    end
    if (BYPASS && wr1_hit && (raddr == rf.waddr1_i)) begin
      value = rf.wdata1_i;
    end else if (BYPASS && wr0_hit && (raddr == rf.waddr0_i)) begin
      value = rf.wdata0_i;
    end
    return value;
  endfunction

  always_comb begin
    rf.rdata1_o = read_port(rf.raddr1_i);
    rf.rdata2_o = read_port(rf.raddr2_i);
  end

  assign rf.fp_o          = regs[FP_INDEX];
  assign rf.sp_o          = regs[SP_INDEX];
  assign rf.wr_conflict_o = wr_conflict_q;

  cpu_scoreboard #(
    .NUM_REGS  (NUM_REGS),
    .IDX_WIDTH (IDX_WIDTH),
    .BYPASS    (BYPASS)
  ) u_scoreboard (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .mark_busy_i (rf.mark_busy_i),
    .mark_idx_i  (rf.mark_idx_i),
    .we1_i       (rf.we1_i),
    .waddr1_i    (rf.waddr1_i),
    .raddr1_i    (rf.raddr1_i),
    .raddr2_i    (rf.raddr2_i),
    .busy1_o     (rf.busy1_o),
    .busy2_o     (rf.busy2_o),
    .busy_vec_o  (rf.busy_vec_o)
  );

endmodule : cpu_registerfile_sb

// File: tb/tb_cpu_registerfile_sb.sv
// Scoreboard bench: two instances (16 regs with bypass, 12 regs without),
// expectations queued by the stimulus and compared by a negedge monitor.
module tb_cpu_registerfile_sb;
  import cpu_pkg::*;

  typedef enum int {
    A_RD1, A_RD2, A_FP, A_SP, A_BVEC, A_BUSY1, A_BUSY2, A_CONF,
    B_RD1, B_RD2, B_BUSY1, B_BVEC, B_CONF
  } sig_e;

  typedef struct {
    string       name;
    sig_e        sig;
    logic [31:0] exp;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  cpu_registerfile_sb_if #(.DATA_WIDTH(32), .IDX_WIDTH(4), .NUM_REGS(16)) ifa ();
  cpu_registerfile_sb_if #(.DATA_WIDTH(32), .IDX_WIDTH(4), .NUM_REGS(12)) ifb ();

  cpu_registerfile_sb #(
    .DATA_WIDTH(32), .NUM_REGS(16), .IDX_WIDTH(4), .BYPASS(1'b1),
    .FP_INDEX(0), .SP_INDEX(1)
  ) u_a (.clk_i(clk), .rst_n_i(rst_n), .rf(ifa));

  cpu_registerfile_sb #(
    .DATA_WIDTH(32), .NUM_REGS(12), .IDX_WIDTH(4), .BYPASS(1'b0),
    .FP_INDEX(0), .SP_INDEX(1)
  ) u_b (.clk_i(clk), .rst_n_i(rst_n), .rf(ifb));

  function automatic logic [31:0] actual(sig_e s);
    case (s)
      A_RD1:   return ifa.rdata1_o;
      A_RD2:   return ifa.rdata2_o;
      A_FP:    return ifa.fp_o;
      A_SP:    return ifa.sp_o;
      A_BVEC:  return 32'(ifa.busy_vec_o);
      A_BUSY1: return 32'(ifa.busy1_o);
      A_BUSY2: return 32'(ifa.busy2_o);
      A_CONF:  return 32'(ifa.wr_conflict_o);
      B_RD1:   return ifb.rdata1_o;
      B_RD2:   return ifb.rdata2_o;
      B_BUSY1: return 32'(ifb.busy1_o);
      B_BVEC:  return 32'(ifb.busy_vec_o);
      B_CONF:  return 32'(ifb.wr_conflict_o);
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  // Monitor: outputs are sampled on the falling edge, away from the update edge.
  exp_t        cur;
  logic [31:0] act;
  initial begin
    forever begin
      @(negedge clk);
      while (sb_q.size() != 0) begin
        cur = sb_q.pop_front();
        act = actual(cur.sig);
        checks++;
        if (act !== cur.exp) begin
          failures++;
          $display("FAIL %s: got 0x%08h expected 0x%08h", cur.name, act, cur.exp);
        end
      end
    end
  end

  task automatic expect_val(input string n, input sig_e s, input logic [31:0] v);
    exp_t e;
    e.name = n;
    e.sig  = s;
    e.exp  = v;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    ifa.we0_i = 1'b0; ifa.we1_i = 1'b0; ifa.mark_busy_i = 1'b0;
    ifb.we0_i = 1'b0; ifb.we1_i = 1'b0; ifb.mark_busy_i = 1'b0;
  endtask

  task automatic wr0(input bit on_a, input logic [3:0] idx, input logic [31:0] d);
    if (on_a) begin ifa.we0_i = 1'b1; ifa.waddr0_i = idx; ifa.wdata0_i = d; end
    else begin ifb.we0_i = 1'b1; ifb.waddr0_i = idx; ifb.wdata0_i = d; end
  endtask

  task automatic wr1(input bit on_a, input logic [3:0] idx, input logic [31:0] d);
    if (on_a) begin ifa.we1_i = 1'b1; ifa.waddr1_i = idx; ifa.wdata1_i = d; end
    else begin ifb.we1_i = 1'b1; ifb.waddr1_i = idx; ifb.wdata1_i = d; end
  endtask

  task automatic mark(input bit on_a, input logic [3:0] idx);
    if (on_a) begin ifa.mark_busy_i = 1'b1; ifa.mark_idx_i = idx; end
    else begin ifb.mark_busy_i = 1'b1; ifb.mark_idx_i = idx; end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] b_exp;

  initial begin
    quiet();
    ifa.waddr0_i = '0; ifa.wdata0_i = '0; ifa.waddr1_i = '0; ifa.wdata1_i = '0;
    ifa.raddr1_i = '0; ifa.raddr2_i = '0; ifa.mark_idx_i = '0;
    ifb.waddr0_i = '0; ifb.wdata0_i = '0; ifb.waddr1_i = '0; ifb.wdata1_i = '0;
    ifb.raddr1_i = '0; ifb.raddr2_i = '0; ifb.mark_idx_i = '0;
    repeat (2) tick();
    rst_n = 1'b1;

    // Reset state
    ifa.raddr1_i = 4'd15; ifa.raddr2_i = 4'd14;
    ifb.raddr1_i = 4'd11; ifb.raddr2_i = 4'd10;
    expect_val("rst_a_rd1", A_RD1, 32'h0);
    expect_val("rst_a_rd2", A_RD2, 32'h0);
    expect_val("rst_a_fp", A_FP, 32'h0);
    expect_val("rst_a_sp", A_SP, 32'h0);
    expect_val("rst_a_bvec", A_BVEC, 32'h0);
    expect_val("rst_a_conf", A_CONF, 32'h0);
    expect_val("rst_b_rd1", B_RD1, 32'h0);
    expect_val("rst_b_bvec", B_BVEC, 32'h0);
    tick();

    // Basic write, bypass vs no bypass
    wr0(1'b1, 4'd3, 32'hDEADBEEF); ifa.raddr1_i = 4'd3;
    wr0(1'b0, 4'd3, 32'hDEADBEEF); ifb.raddr1_i = 4'd3;
    expect_val("wr_a_bypass", A_RD1, 32'hDEADBEEF);
    expect_val("wr_b_nobypass", B_RD1, 32'h0);
    tick(); quiet();
    expect_val("wr_a_stored", A_RD1, 32'hDEADBEEF);
    expect_val("wr_b_stored", B_RD1, 32'hDEADBEEF);
    tick();

    // Dual-port conflict on index 5
    wr0(1'b1, 4'd5, 32'h11); wr1(1'b1, 4'd5, 32'h22);
    wr0(1'b0, 4'd5, 32'h11); wr1(1'b0, 4'd5, 32'h22);
    ifa.raddr1_i = 4'd5; ifa.raddr2_i = 4'd3; ifb.raddr1_i = 4'd5;
    expect_val("conf_a_bypass_prio", A_RD1, 32'h22);
    expect_val("conf_a_pre", A_CONF, 32'h0);
    expect_val("conf_b_pre_rd", B_RD1, 32'h0);
    expect_val("conf_b_pre", B_CONF, 32'h0);
    tick(); quiet();
    expect_val("conf_a_stored", A_RD1, 32'h22);
    expect_val("conf_a_other", A_RD2, 32'hDEADBEEF);
    expect_val("conf_a_pulse", A_CONF, 32'h1);
    expect_val("conf_b_stored", B_RD1, 32'h22);
    expect_val("conf_b_pulse", B_CONF, 32'h1);
    tick();
    expect_val("conf_a_drop", A_CONF, 32'h0);
    expect_val("conf_b_drop", B_CONF, 32'h0);
    tick();

    // Dual write to different indices feeds fp/sp taps one cycle later
    wr0(1'b1, 4'd0, 32'h100); wr1(1'b1, 4'd1, 32'h200);
    expect_val("fp_no_bypass", A_FP, 32'h0);
    expect_val("sp_no_bypass", A_SP, 32'h0);
    tick(); quiet();
    expect_val("fp_stored", A_FP, 32'h100);
    expect_val("sp_stored", A_SP, 32'h200);
    expect_val("diff_idx_no_conf", A_CONF, 32'h0);
    tick();

    // Scoreboard set / clear with bypass
    mark(1'b1, 4'd7); ifa.raddr1_i = 4'd7;
    expect_val("sb_mark_same_cycle", A_BUSY1, 32'h0);
    tick(); quiet();
    expect_val("sb_bvec_set", A_BVEC, 32'h80);
    expect_val("sb_busy1_set", A_BUSY1, 32'h1);
    tick();
    wr1(1'b1, 4'd7, 32'hCAFE);
    expect_val("sb_busy1_fwd_clear", A_BUSY1, 32'h0);
    expect_val("sb_rd1_fwd", A_RD1, 32'hCAFE);
    expect_val("sb_bvec_still_set", A_BVEC, 32'h80);
    tick(); quiet();
    expect_val("sb_bvec_cleared", A_BVEC, 32'h0);
    expect_val("sb_rd1_stored", A_RD1, 32'hCAFE);
    expect_val("sb_busy1_cleared", A_BUSY1, 32'h0);
    tick();
    mark(1'b1, 4'd7);
    tick(); quiet();
    wr0(1'b1, 4'd7, 32'h77);
    expect_val("sb_p0_busy_same", A_BUSY1, 32'h1);
    tick(); quiet();
    expect_val("sb_p0_keeps_bit", A_BVEC, 32'h80);
    expect_val("sb_p0_keeps_busy1", A_BUSY1, 32'h1);
    expect_val("sb_p0_data", A_RD1, 32'h77);
    tick();

    // Scoreboard without bypass reports the raw bit
    mark(1'b0, 4'd7); ifb.raddr1_i = 4'd7;
    tick(); quiet();
    wr1(1'b0, 4'd7, 32'hCAFE);
    expect_val("sb_b_raw_busy", B_BUSY1, 32'h1);
    expect_val("sb_b_raw_data", B_RD1, 32'h0);
    tick(); quiet();
    expect_val("sb_b_cleared", B_BUSY1, 32'h0);
    expect_val("sb_b_stored", B_RD1, 32'hCAFE);
    expect_val("sb_b_bvec", B_BVEC, 32'h0);
    tick();

    // Set beats clear on the same index; no counting on re-mark
    mark(1'b1, 4'd9);
    tick(); quiet();
    mark(1'b1, 4'd9); wr1(1'b1, 4'd9, 32'h99); ifa.raddr2_i = 4'd9;
    expect_val("coll_busy2_same", A_BUSY2, 32'h1);
    expect_val("coll_rd2_fwd", A_RD2, 32'h99);
    tick(); quiet();
    expect_val("coll_bvec", A_BVEC, 32'h280);
    expect_val("coll_rd2_stored", A_RD2, 32'h99);
    expect_val("coll_busy2", A_BUSY2, 32'h1);
    tick();
    mark(1'b1, 4'd9);
    tick(); quiet();
    expect_val("remark_bvec", A_BVEC, 32'h280);
    wr1(1'b1, 4'd9, 32'h9A);
    tick(); quiet();
    expect_val("single_clear_bvec", A_BVEC, 32'h80);
    expect_val("single_clear_rd2", A_RD2, 32'h9A);
    tick();

    // Out-of-range writes, reads and marks on the 12-entry instance
    wr0(1'b0, 4'd13, 32'hBAD); wr1(1'b0, 4'd12, 32'hBAE); mark(1'b0, 4'd13);
    ifb.raddr1_i = 4'd13;
    expect_val("oor_rd_same", B_RD1, 32'h0);
    expect_val("oor_busy_same", B_BUSY1, 32'h0);
    tick(); quiet();
    expect_val("oor_rd_after", B_RD1, 32'h0);
    expect_val("oor_busy_after", B_BUSY1, 32'h0);
    expect_val("oor_bvec", B_BVEC, 32'h0);
    for (int i = 0; i < 12; i++) begin
      ifb.raddr2_i = 4'(i);
      case (i)
        3:       b_exp = 32'hDEADBEEF;
        5:       b_exp = 32'h22;
        7:       b_exp = 32'hCAFE;
        default: b_exp = 32'h0;
      endcase
      expect_val($sformatf("oor_sweep_r%0d", i), B_RD2, b_exp);
      tick();
    end

    // Asynchronous reset between edges, with an in-flight write discarded
    expect_val("pre_rst_fp", A_FP, 32'h100);
    expect_val("pre_rst_sp", A_SP, 32'h200);
    expect_val("pre_rst_bvec", A_BVEC, 32'h80);
    tick();
    rst_n = 1'b0;
    wr0(1'b1, 4'd2, 32'h555);
    expect_val("async_rst_fp", A_FP, 32'h0);
    expect_val("async_rst_sp", A_SP, 32'h0);
    expect_val("async_rst_bvec", A_BVEC, 32'h0);
    expect_val("async_rst_conf", A_CONF, 32'h0);
    tick();
    rst_n = 1'b1;
    wr0(1'b1, 4'd2, 32'h1234); ifa.raddr1_i = 4'd2; ifa.raddr2_i = 4'd7;
    expect_val("post_rst_fwd", A_RD1, 32'h1234);
    expect_val("post_rst_r7", A_RD2, 32'h0);
    tick(); quiet();
    expect_val("post_rst_write", A_RD1, 32'h1234);
    expect_val("post_rst_fp", A_FP, 32'h0);
    expect_val("post_rst_bvec", A_BVEC, 32'h0);
    tick();

    for (int w = 0; w < 10 && sb_q.size() != 0; w++) @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_cpu_registerfile_sb
